// File: rtl/muldiv_if.sv
// Handshake and HI/LO access bundle for muldiv_unit.
//   master: start, op, a, b, hi_we, lo_we, wdata  (requester side)
//   slave : busy, done, hi, lo, div_by_zero       (unit side)
interface muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// One shift-add (multiply) or restoring-divide step per cycle over operand
// magnitudes, followed by a sign-fixup cycle that writes HI/LO.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - muldiv_if slave: start/op/a/b request, hi_we/lo_we/wdata direct
//          HI/LO writes, busy/done/hi/lo/div_by_zero status and results
// op: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
module muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic      clk,
  input logic      rst,
  muldiv_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  // acc_hi_q: partial product high half / partial remainder
  // acc_lo_q: multiplier shifting out + product low half / dividend shifting out + quotient
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             busy_q, done_q, dbz_q;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? -x : x;
  endfunction

  logic             is_div, neg_a, neg_b, div_zero, div_ge;
  logic [WIDTH-1:0] mag_a, mag_b, start_init;
  logic [WIDTH:0]   mul_sum, div_shift;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] calc_hi, calc_lo, fix_hi, fix_lo;
  logic [2*WIDTH-1:0] prod, prod_fixed;

  always_comb begin
    is_div   = op_q[1];
    neg_a    = op_q[0] & a_q[WIDTH-1];
    neg_b    = op_q[0] & b_q[WIDTH-1];
    mag_a    = mag(a_q, op_q[0]);
    mag_b    = mag(b_q, op_q[0]);
    div_zero = is_div && (b_q == '0);

    // Dividend magnitude for divides, multiplier magnitude for multiplies.
    start_init = bus.op[1] ? mag(bus.a, bus.op[0]) : mag(bus.b, bus.op[0]);

    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mag_a} : '0);
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, mag_b};
    // When div_ge holds the difference is below mag_b, so WIDTH bits suffice.
    div_diff  = div_shift[WIDTH-1:0] - mag_b;

    if (is_div) begin
      calc_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
      calc_lo = {acc_lo_q[WIDTH-2:0], div_ge};
    end else begin
      calc_hi = mul_sum[WIDTH:1];
      calc_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end

    prod       = {acc_hi_q, acc_lo_q};
    prod_fixed = (neg_a ^ neg_b) ? -prod : prod;
    if (!is_div) begin
      fix_hi = prod_fixed[2*WIDTH-1:WIDTH];
      fix_lo = prod_fixed[WIDTH-1:0];
    end else if (div_zero) begin
      fix_hi = a_q;
      fix_lo = '1;
    end else begin
      // Quotient sign is the XOR of operand signs; remainder follows the dividend.
      fix_lo = (neg_a ^ neg_b) ? -acc_lo_q : acc_lo_q;
      fix_hi = neg_a ? -acc_hi_q : acc_hi_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.hi_we) hi_q <= bus.wdata;
          if (bus.lo_we) lo_q <= bus.wdata;
          if (bus.start) begin
            a_q      <= bus.a;
            b_q      <= bus.b;
            op_q     <= bus.op;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= start_init;
            dbz_q    <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= StCalc;
          end
        end
        StCalc: begin
          acc_hi_q <= calc_hi;
          acc_lo_q <= calc_lo;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= StFix;
        end
        StFix: begin
          hi_q    <= fix_hi;
          lo_q    <= fix_lo;
          dbz_q   <= div_zero;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at WIDTH=32.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  muldiv_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge: drives start for one edge, then waits for done.
  // lat counts edges from the accepting edge to the edge that raised done.
  task automatic do_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input logic hw, input logic [31:0] wd,
                       output int lat, output int bcnt, output logic dbz0,
                       output logic [31:0] hi0);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = av;
    bus.b     = bv;
    bus.hi_we = hw;
    bus.wdata = wd;
    @(negedge clk);
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    dbz0 = bus.div_by_zero;
    hi0  = bus.hi;
    lat  = 0;
    bcnt = 0;
    while (!bus.done && lat < 200) begin
      if (bus.busy) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  int          lat, bcnt;
  logic        dbz0, saw_done;
  logic [31:0] hi0;

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_hi", bus.hi, 0);
    check_eq("rst_lo", bus.lo, 0);
    check_eq("rst_dbz", bus.div_by_zero, 0);

    // MULTU max*max, started at the first edge after reset release
    rst = 1'b0;
    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, lat, bcnt, dbz0, hi0);
    check_eq("multu_lat", lat, 33);
    check_eq("multu_busy_cycles", bcnt, 33);
    check_eq("multu_busy_at_done", bus.busy, 0);
    check_eq("multu_hi", bus.hi, 32'hFFFF_FFFE);
    check_eq("multu_lo", bus.lo, 32'h0000_0001);
    check_eq("multu_dbz", bus.div_by_zero, 0);

    // MULT -3*7, then back-to-back MULTU 6*7 launched in the done cycle
    @(negedge clk);
    do_op(2'b01, 32'hFFFF_FFFD, 32'h7, 1'b0, 0, lat, bcnt, dbz0, hi0);
    check_eq("mult_hi", bus.hi, 32'hFFFF_FFFF);
    check_eq("mult_lo", bus.lo, 32'hFFFF_FFEB);
    do_op(2'b00, 32'h6, 32'h7, 1'b0, 0, lat, bcnt, dbz0, hi0);
    check_eq("b2b_lat", lat, 33);
    check_eq("b2b_hi", bus.hi, 0);
    check_eq("b2b_lo", bus.lo, 42);
    @(negedge clk);
    check_eq("done_one_cycle", bus.done, 0);

    // Signed divides
    do_op(2'b11, 32'hFFFF_FFF9, 32'h2, 1'b0, 0, lat, bcnt, dbz0, hi0);
    check_eq("div_neg_lo", bus.lo, 32'hFFFF_FFFD);
    check_eq("div_neg_hi", bus.hi, 32'hFFFF_FFFF);
    @(negedge clk);
    do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, lat, bcnt, dbz0, hi0);
    check_eq("div_min_lo", bus.lo, 32'h8000_0000);
    check_eq("div_min_hi", bus.hi, 0);
    check_eq("div_min_dbz", bus.div_by_zero, 0);
    @(negedge clk);
    do_op(2'b11, 32'h64, 32'hFFFF_FFF9, 1'b0, 0, lat, bcnt, dbz0, hi0);
    check_eq("div_negb_lo", bus.lo, 32'hFFFF_FFF2);
    check_eq("div_negb_hi", bus.hi, 32'h2);

    // Divide by zero, then a multiply clears the flag at its start
    @(negedge clk);
    do_op(2'b10, 32'h1234, 32'h0, 1'b0, 0, lat, bcnt, dbz0, hi0);
    check_eq("dbz_lat", lat, 33);
    check_eq("dbz_hi", bus.hi, 32'h1234);
    check_eq("dbz_lo", bus.lo, 32'hFFFF_FFFF);
    check_eq("dbz_flag", bus.div_by_zero, 1);
    @(negedge clk);
    do_op(2'b00, 32'h2, 32'h3, 1'b0, 0, lat, bcnt, dbz0, hi0);
    check_eq("dbz_cleared_at_start", dbz0, 0);
    check_eq("dbz_after_mul_lo", bus.lo, 6);

    // Direct HI/LO writes in IDLE
    @(negedge clk);
    bus.hi_we = 1'b1;
    bus.wdata = 32'h1111;
    @(negedge clk);
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b1;
    bus.wdata = 32'h2222;
    check_eq("mthi", bus.hi, 32'h1111);
    @(negedge clk);
    bus.lo_we = 1'b0;
    check_eq("mtlo", bus.lo, 32'h2222);
    check_eq("mtlo_keeps_hi", bus.hi, 32'h1111);

    // hi_we together with start: write lands now, FIX overwrites later
    do_op(2'b00, 32'h3, 32'h5, 1'b1, 32'h5555, lat, bcnt, dbz0, hi0);
    check_eq("mthi_with_start", hi0, 32'h5555);
    check_eq("start_mthi_hi", bus.hi, 0);
    check_eq("start_mthi_lo", bus.lo, 15);

    // Mid-operation start/hi_we are ignored
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.a     = 32'h1_0000;
    bus.b     = 32'h1_0000;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    repeat (9) begin
      @(negedge clk);
      lat++;
    end
    check_eq("calc_hold_hi", bus.hi, 0);
    check_eq("calc_hold_lo", bus.lo, 15);
    bus.start = 1'b1;
    bus.a     = 32'h5;
    bus.b     = 32'h5;
    bus.hi_we = 1'b1;
    bus.wdata = 32'hAAAA;
    @(negedge clk);
    lat++;
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    check_eq("busy_hi_we_ignored", bus.hi, 0);
    while (!bus.done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check_eq("ignore_lat", lat, 33);
    check_eq("ignore_hi", bus.hi, 1);
    check_eq("ignore_lo", bus.lo, 0);

    // Reset aborts a divide in flight
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b11;
    bus.a     = 32'h64;
    bus.b     = 32'h7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("abort_busy", bus.busy, 0);
    check_eq("abort_hi", bus.hi, 0);
    check_eq("abort_lo", bus.lo, 0);
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
    end
    rst = 1'b0;
    do_op(2'b10, 32'h64, 32'h7, 1'b0, 0, lat, bcnt, dbz0, hi0);
    check_eq("abort_no_done", saw_done, 0);
    check_eq("post_rst_lat", lat, 33);
    check_eq("post_rst_lo", bus.lo, 14);
    check_eq("post_rst_hi", bus.hi, 2);
    @(negedge clk);
    do_op(2'b11, 32'hFFFF_FF9C, 32'h7, 1'b0, 0, lat, bcnt, dbz0, hi0);
    check_eq("div_nega_lo", bus.lo, 32'hFFFF_FFF2);
    check_eq("div_nega_hi", bus.hi, 32'hFFFF_FFFE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and HI/LO register width; legal values are 8 to 64.
REQ-002 SHALL have parameter CNT_W, default 6, giving the iteration counter width; it SHALL satisfy 2^CNT_W > WIDTH.
REQ-003 SHALL have port: clk, input, 1, sole clock; all state changes on the rising edge.
REQ-004 SHALL have port: rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port: start, input, 1, request to begin an operation.
REQ-006 SHALL have port: op, input, 2, operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-007 SHALL have ports: a and b, inputs, WIDTH each; a is the multiplicand or dividend, b is the multiplier or divisor.
REQ-008 SHALL have ports: hi_we and lo_we, inputs, 1 each; wdata, input, WIDTH; together these provide direct HI/LO writes (mthi/mtlo).
REQ-009 SHALL have port: busy, output, 1, operation in progress.
REQ-010 SHALL have port: done, output, 1, one-cycle completion pulse.
REQ-011 SHALL have ports: hi and lo, outputs, WIDTH each, registered HI/LO results.
REQ-012 SHALL have port: div_by_zero, output, 1, flag set when the last divide had b == 0.

Function
REQ-013 SHALL implement FSM states IDLE, CALC and FIX, with transitions IDLE->CALC on start, CALC->FIX after WIDTH iterations, and FIX->IDLE unconditionally.
REQ-014 SHALL accept start only in IDLE; at the accepting edge it latches a, b and op, loads the counter with 0 and enters CALC.
REQ-015 SHALL ignore start, a, b and op while not in IDLE.
REQ-016 SHALL hold busy = 1 in CALC and FIX; busy = 0 in IDLE.
REQ-017 SHALL perform one shift-add multiply iteration or one restoring-divide iteration per CALC cycle, over operand magnitudes.
REQ-018 SHALL, in FIX, apply sign correction for signed ops, write hi and lo, and register done = 1 for exactly the next cycle.
REQ-019 Latency: for start accepted at edge k, SHALL assert done and present updated hi/lo after edge k+WIDTH+1 (33 cycles at WIDTH=32); busy SHALL fall at that same edge.
REQ-020 SHALL accept a start asserted during the done cycle, with no dead cycle.
REQ-021 Multiply: {hi,lo} SHALL equal the full 2*WIDTH-bit product; for MULT the product is negated when the operand signs differ.
REQ-022 Divide: lo SHALL be the quotient and hi the remainder; for DIV the quotient is negated when signs differ and the remainder takes the dividend's sign.
REQ-023 Divide with b == 0: SHALL use the full latency, set hi = a and lo = all ones, and set div_by_zero = 1.
REQ-024 SHALL clear div_by_zero at the next accepted start; a divide with a nonzero divisor or any multiply leaves it 0.
REQ-025 DIV of most-negative by -1: SHALL give lo = most-negative (wrap) and hi = 0, with no flag.
REQ-026 SHALL hold hi and lo unchanged in CALC and FIX until the FIX write.
REQ-027 hi_we/lo_we: SHALL write wdata to hi/lo at the edge only in IDLE; these writes are ignored in CALC and FIX.
REQ-028 hi_we/lo_we together with start in IDLE: SHALL perform both actions; the later FIX write overwrites.

Reset
REQ-029 rst high SHALL immediately force IDLE and set hi = 0, lo = 0, busy = 0, done = 0, div_by_zero = 0 and clear the counter and operand registers.
REQ-030 Reset during CALC or FIX SHALL abort the operation, with no done pulse and no HI/LO update.
REQ-031 After rst falls, start SHALL be accepted at the first rising edge.

Verification (WIDTH=32)
REQ-032 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done exactly 33 cycles after the start edge; hi=0xFFFFFFFE, lo=0x00000001; busy high for 33 cycles.
REQ-033 MULT a=0xFFFFFFFD b=0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; then a back-to-back start in the done cycle is accepted.
REQ-034 DIV a=0xFFFFFFF9 b=0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-035 DIVU a=0x1234 b=0 -> hi=0x00001234, lo=0xFFFFFFFF, div_by_zero=1; the next MULTU start clears div_by_zero.
REQ-036 Start MULTU, then at cycle 10 pulse start with new operands and hi_we with wdata=0xAAAA -> both ignored; the original result is delivered.
REQ-037 Start DIV, assert rst at cycle 12 -> busy=0, hi=lo=0 immediately; no done pulse; a fresh start after reset completes correctly.
